// File: rtl/triple_shift_pkg.sv
// rtl/triple_shift_pkg.sv - shared op and state types for the triplet packer
package triple_shift_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'b00,
    OP_SWAP  = 2'b01,
    OP_ROT   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/triple_shift_regs.sv
// rtl/triple_shift_regs.sv - a/b/c chain datapath with in-place swap and rotate
module triple_shift_regs
  import triple_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_ld_en,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_c
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;

  // All three registers update together from pre-edge values; clear wins over any op
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (i_ld_en) begin
      unique case (i_op)
        OP_SHIFT: begin
          r_a <= i_data;
          r_b <= r_a;
          r_c <= r_b;
        end
        OP_SWAP: begin
          r_a <= r_b;
          r_b <= r_a;
        end
        OP_ROT: begin
          r_a <= r_c;
          r_b <= r_a;
          r_c <= r_b;
        end
        default: begin
          r_a <= '0;
          r_b <= '0;
          r_c <= '0;
        end
      endcase
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c;

endmodule

// File: rtl/triple_shift_pipe.sv
// rtl/triple_shift_pipe.sv - stream-to-triplet packer with fill/full handshake control
module triple_shift_pipe
  import triple_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       count
);

  state_e     r_state;
  logic [1:0] r_count;
  op_e        w_op;
  logic       w_accept;
  logic       w_clr;

  assign w_op     = op_e'(in_op);
  // in_ready depends on rst_n so no beat is taken while reset is held
  assign in_ready = rst_n & (r_state == FILL);
  assign out_valid = (r_state == FULL);
  assign w_accept = in_valid & in_ready;
  assign w_clr    = ~rst_n | (w_accept & (w_op == OP_CLEAR));

  triple_shift_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_ld_en (w_accept),
    .i_op    (w_op),
    .i_data  (in_data),
    .o_a     (out_a),
    .o_b     (out_b),
    .o_c     (out_c)
  );

  // Fill/full control: count loaded words, hand the triplet off, then restart filling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_count <= 2'd0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_op == OP_SHIFT) begin
              r_count <= r_count + 2'd1;
              if (r_count == 2'd2) begin
                r_state <= FULL;
              end
            end else if (w_op == OP_CLEAR) begin
              r_count <= 2'd0;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            r_count <= 2'd0;
            r_state <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
          r_count <= 2'd0;
        end
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_triple_shift_pipe.sv
// tb/tb_triple_shift_pipe.sv - directed and random checks of the triplet packer
module tb_triple_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [7:0] out_c;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  // reference state: chain as an array {a,b,c}, words loaded, triplet pending
  logic [7:0] m_ch[3];
  int         m_cnt;
  bit         m_full;

  always #5 clk = ~clk;

  triple_shift_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // next reference state from the current inputs, applied at the coming edge
  task automatic model_step();
    logic [7:0] t[3];
    t = m_ch;
    if (!rst_n) begin
      m_ch = '{8'h00, 8'h00, 8'h00};
      m_cnt = 0;
      m_full = 0;
    end else if (m_full) begin
      if (out_ready) begin
        m_cnt = 0;
        m_full = 0;
      end
    end else if (in_valid) begin
      case (in_op)
        2'b00: begin
          m_ch = '{in_data, t[0], t[1]};
          m_cnt++;
          if (m_cnt == 3) m_full = 1;
        end
        2'b01: m_ch = '{t[1], t[0], t[2]};
        2'b10: m_ch = '{t[2], t[0], t[1]};
        default: begin
          m_ch = '{8'h00, 8'h00, 8'h00};
          m_cnt = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"}, in_ready, rst_n && !m_full);
    check({tag, ".out_valid"}, out_valid, m_full);
    check({tag, ".a"}, out_a, m_ch[0]);
    check({tag, ".b"}, out_b, m_ch[1]);
    check({tag, ".c"}, out_c, m_ch[2]);
    check({tag, ".count"}, count, m_cnt);
  endtask

  // one clock: set inputs, advance the model, sample #1 after the edge
  task automatic cyc(input logic rn, input logic v, input logic [1:0] op,
                     input logic [7:0] d, input logic ord, input string tag);
    rst_n = rn; in_valid = v; in_op = op; in_data = d; out_ready = ord;
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, "rst");
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = 8'h00; out_ready = 1'b0;
    m_ch = '{8'h00, 8'h00, 8'h00}; m_cnt = 0; m_full = 0;
    @(negedge clk);
    do_reset();

    // three shifts fill the chain
    cyc(1, 1, 2'b00, 8'h11, 0, "fill1");
    cyc(1, 1, 2'b00, 8'h22, 0, "fill2");
    cyc(1, 1, 2'b00, 8'h33, 0, "fill3");
    check("tp1_valid", out_valid, 1'b1);
    check("tp1_abc", {out_a, out_b, out_c}, 24'h332211);
    check("tp1_count", count, 2'd3);

    // backpressure: held beat ignored while full
    for (int i = 0; i < 5; i++) cyc(1, 1, 2'b00, 8'h44, 0, "hold");
    check("tp2_frozen", {in_ready, out_a, out_b, out_c, count}, {1'b0, 24'h332211, 2'd3});
    cyc(1, 1, 2'b00, 8'h44, 1, "drain");
    check("tp2_count0", count, 2'd0);
    cyc(1, 1, 2'b00, 8'h44, 0, "take44");
    check("tp2_abc", {out_a, out_b, out_c, count}, {24'h443322, 2'd1});

    // swap
    do_reset();
    cyc(1, 1, 2'b00, 8'h11, 0, "sw1");
    cyc(1, 1, 2'b00, 8'h22, 0, "sw2");
    cyc(1, 1, 2'b01, 8'hEE, 0, "swap");
    check("tp3_swap", {out_a, out_b, count}, {16'h1122, 2'd2});
    cyc(1, 1, 2'b00, 8'h33, 0, "sw3");
    check("tp3_full", {out_valid, out_a, out_b, out_c}, {1'b1, 24'h331122});
    cyc(1, 0, 2'b00, 8'h00, 1, "sw_drain");

    // rotate
    do_reset();
    cyc(1, 1, 2'b00, 8'h11, 0, "rt1");
    cyc(1, 1, 2'b00, 8'h22, 0, "rt2");
    cyc(1, 1, 2'b10, 8'hEE, 0, "rot");
    check("tp4_rot", {out_a, out_b, out_c, count}, {24'h002211, 2'd2});

    // reset mid-fill
    do_reset();
    cyc(1, 1, 2'b00, 8'h11, 0, "mr1");
    cyc(1, 1, 2'b00, 8'h22, 0, "mr2");
    cyc(0, 1, 2'b00, 8'h33, 0, "midrst");
    check("tp5_rst", {in_ready, out_valid, out_a, out_b, out_c, count}, 28'h0);
    rst_n = 1'b1;
    #1;
    check("tp5_release", in_ready, 1'b1);

    // clear then refill
    cyc(1, 1, 2'b00, 8'hAA, 0, "cl1");
    cyc(1, 1, 2'b00, 8'hBB, 0, "cl2");
    cyc(1, 1, 2'b11, 8'hEE, 0, "clear");
    check("tp6_clear", {out_a, out_b, out_c, count}, 26'h0);
    cyc(1, 1, 2'b00, 8'h01, 0, "cl3");
    cyc(1, 1, 2'b00, 8'h02, 0, "cl4");
    cyc(1, 1, 2'b00, 8'h03, 0, "cl5");
    check("tp6_abc", {out_valid, out_a, out_b, out_c}, {1'b1, 24'h030201});

    // reset while full with out_ready high discards the triplet
    cyc(0, 0, 2'b00, 8'h00, 1, "fullrst");
    check("full_rst", {out_valid, count}, 3'b000);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
          (($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3))),
          8'($urandom), ($urandom_range(0, 1) == 1), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
